exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, meaning number of 32-bit data-memory words.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning data-memory address width; MEM_DEPTH = 2**ADDR_W.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clock (input, 1) is the rising-edge clock; rst_n (input, 1) is the active-low asynchronous reset.
REQ-004 opcode  input  4  instruction opcode.
REQ-005 xrs  input  32  register operand A; also the memory address source.
REQ-006 xrt  input  32  register operand B; also the memory write data.
REQ-007 y  input  32  sign-extended immediate.
REQ-008 alu_op  output  3  decoded ALU operation.
REQ-009 mem_read, mem_write, alu_src, reg_wrt, branch_zero, branch_neg, jump, jump_mem  output  1 each  decoded control flags.
REQ-010 wb_ctrl  output  2  write-back select: 00 = PC+y, 01 = memory data, 10 = ALU result.
REQ-011 alu_result  output  32  ALU result; z and n  output  1 each  are the zero and negative flags.
REQ-012 read_data  output  32  data-memory read value.

Function
REQ-013 Decode SHALL be purely combinational from opcode; every flag not listed for an opcode SHALL be 0, and alu_op SHALL default to PASS.
REQ-014 Opcode map:
- 0000 NOP: all flags 0.
- 1111 SVPC: reg_wrt, wb=00.
- 1110 LD: mem_read, reg_wrt, wb=01.
- 0011 ST: mem_write.
- 0100 ADD: alu_op=ADD, alu_src=0, reg_wrt, wb=10.
- 0101 INC: alu_op=ADD, alu_src=1, reg_wrt, wb=10.
- 0110 NEG: alu_op=NEG, reg_wrt, wb=10.
- 0111 SUB: alu_op=SUB, alu_src=0, reg_wrt, wb=10.
- 1000 J: jump.
- 1001 BRZ: branch_zero, alu_op=PASS.
- 1010 JM: jump, jump_mem, mem_read.
- 1011 BRN: branch_neg, alu_op=PASS.
- All other opcodes SHALL decode as NOP.
REQ-015 alu_op encodings SHALL be: 000 PASS (result = A), 001 ADD (A+B), 010 SUB (A-B), 011 NEG (0-A); 1xx SHALL yield 0.
REQ-016 ALU operand A SHALL be xrs; operand B SHALL be y when alu_src=1, else xrt.
REQ-017 Arithmetic SHALL be 32-bit two's complement, wrapping modulo 2^32, with no carry or overflow output.
REQ-018 z SHALL be 1 iff alu_result == 0; n SHALL equal alu_result[31]; both SHALL be combinational.
REQ-019 The data-memory address SHALL be xrs[ADDR_W-1:0]; upper address bits SHALL be ignored, so addresses wrap.
REQ-020 Memory writes: when mem_write=1 and rst_n=1, mem[addr] SHALL be written with xrt on the rising clock edge.
REQ-021 Memory reads: read_data SHALL be combinational, equal to mem[addr] when mem_read=1 and 0 otherwise.
REQ-022 A read and a write to the same address in the same cycle SHALL return the old data before the edge and the new data after it; no bypass.
REQ-023 The alu, control and memory paths SHALL have zero latency apart from the write in REQ-020.

Reset
REQ-024 rst_n=0 SHALL clear all memory words to 0 asynchronously and block writes; decode and ALU outputs are unaffected by reset.
REQ-025 After rst_n rises, the first write SHALL occur on the first rising edge with mem_write=1.

Structure
REQ-026 The opcode constants, the alu_op encodings and the wb_ctrl encodings SHALL live in a shared package, exec_pkg.
REQ-027 The ALU SHALL be one sub-module, exec_alu; decode and memory SHALL be in the top module.

Verification
REQ-028 Decode sweep: apply all 16 opcodes -> flags exactly per REQ-014 (e.g., 0101 gives alu_op=001, alu_src=1, reg_wrt=1, wb=10).
REQ-029 ALU operations:
- SUB with xrs=5, xrt=5 -> alu_result=0, z=1, n=0.
- SUB with xrs=3, xrt=7 -> alu_result=0xFFFFFFFC, n=1.
- NEG with xrs=1 -> 0xFFFFFFFF.
- ADD with xrs=0xFFFFFFFF, xrt=1 -> 0, z=1.
REQ-030 Store then load: ST with xrs=0x10, xrt=0xDEADBEEF, one clock edge; then LD with xrs=0x10 -> read_data=0xDEADBEEF; with opcode=ADD -> read_data=0.
REQ-031 Address wrap: ST with xrs=0x110, xrt=7; then LD with xrs=0x10 -> read_data=7.
REQ-032 Reset: write 0x55 to address 3, pulse rst_n low mid-cycle (not edge-aligned) -> LD address 3 returns 0 immediately; a ST held during reset does not write.

Source files
------------

// File: rtl/exec_pkg.sv
// exec_pkg: opcode, alu_op and write-back encodings shared by the execute unit.
package exec_pkg;
  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_NEG  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_BRZ  = 4'b1001;
  localparam logic [3:0] OP_JM   = 4'b1010;
  localparam logic [3:0] OP_BRN  = 4'b1011;
  localparam logic [3:0] OP_LD   = 4'b1110;
  localparam logic [3:0] OP_SVPC = 4'b1111;
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_NEG  = 3'b011;
  localparam logic [1:0] WB_PC  = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_ALU = 2'b10;
  typedef struct packed {
    logic [2:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_wrt;
    logic       branch_zero;
    logic       branch_neg;
    logic       jump;
    logic       jump_mem;
    logic [1:0] wb_ctrl;
  } ctrl_t;
endpackage

// File: rtl/exec_alu.sv
// exec_alu: 32-bit wrapping ALU with combinational zero/negative flags.
module exec_alu
  import exec_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result,
  output logic        o_z,
  output logic        o_n
);
  always_comb begin
    o_result = i_op == ALU_PASS ? i_a :
               i_op == ALU_ADD  ? i_a + i_b :
               i_op == ALU_SUB  ? i_a - i_b :
               i_op == ALU_NEG  ? 32'd0 - i_a : 32'd0;
    o_z = o_result == 32'd0;
    o_n = o_result[31];
  end
endmodule

// File: rtl/exec_unit.sv
// exec_unit: opcode decode, ALU and data memory with async-clear reset.
module exec_unit
  import exec_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 8
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic [3:0]  opcode,
  input  logic [31:0] xrs,
  input  logic [31:0] xrt,
  input  logic [31:0] y,
  output logic [2:0]  alu_op,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic        reg_wrt,
  output logic        branch_zero,
  output logic        branch_neg,
  output logic        jump,
  output logic        jump_mem,
  output logic [1:0]  wb_ctrl,
  output logic [31:0] alu_result,
  output logic        z,
  output logic        n,
  output logic [31:0] read_data
);
  ctrl_t             w_ctrl;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       r_mem [MEM_DEPTH];
  always_comb begin
    w_ctrl = '0;
    case (opcode)
      OP_SVPC: begin w_ctrl.reg_wrt = 1'b1; w_ctrl.wb_ctrl = WB_PC; end
      OP_LD:   begin w_ctrl.mem_read = 1'b1; w_ctrl.reg_wrt = 1'b1; w_ctrl.wb_ctrl = WB_MEM; end
      OP_ST:   w_ctrl.mem_write = 1'b1;
      OP_ADD:  begin w_ctrl.alu_op = ALU_ADD; w_ctrl.reg_wrt = 1'b1; w_ctrl.wb_ctrl = WB_ALU; end
      OP_INC:  begin w_ctrl.alu_op = ALU_ADD; w_ctrl.alu_src = 1'b1; w_ctrl.reg_wrt = 1'b1; w_ctrl.wb_ctrl = WB_ALU; end
      OP_NEG:  begin w_ctrl.alu_op = ALU_NEG; w_ctrl.reg_wrt = 1'b1; w_ctrl.wb_ctrl = WB_ALU; end
      OP_SUB:  begin w_ctrl.alu_op = ALU_SUB; w_ctrl.reg_wrt = 1'b1; w_ctrl.wb_ctrl = WB_ALU; end
      OP_J:    w_ctrl.jump = 1'b1;
      OP_BRZ:  w_ctrl.branch_zero = 1'b1;
      OP_JM:   begin w_ctrl.jump = 1'b1; w_ctrl.jump_mem = 1'b1; w_ctrl.mem_read = 1'b1; end
      OP_BRN:  w_ctrl.branch_neg = 1'b1;
      default: w_ctrl = '0;
    endcase
  end
  assign {alu_op, mem_read, mem_write, alu_src, reg_wrt, branch_zero, branch_neg,
          jump, jump_mem, wb_ctrl} = w_ctrl;
  exec_alu u_alu (
    .i_op     (alu_op),
    .i_a      (xrs),
    .i_b      (alu_src ? y : xrt),
    .o_result (alu_result),
    .o_z      (z),
    .o_n      (n)
  );
  // Upper address bits are dropped so accesses wrap around the memory.
  assign w_addr = xrs[ADDR_W-1:0];
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
    end else if (mem_write) begin
      r_mem[w_addr] <= xrt;
    end
  end
  assign read_data = mem_read ? r_mem[w_addr] : 32'd0;
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed vectors with hand-computed expectations for exec_unit.
module tb_exec_unit;
  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  opcode = 4'd0;
  logic [31:0] xrs = '0, xrt = '0, y = '0;
  logic [2:0]  alu_op;
  logic        mem_read, mem_write, alu_src, reg_wrt, branch_zero, branch_neg, jump, jump_mem;
  logic [1:0]  wb_ctrl;
  logic [31:0] alu_result, read_data;
  logic        z, n;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [12:0] exp_dec [16];

  exec_unit dut (
    .clock(clock), .rst_n(rst_n), .opcode(opcode), .xrs(xrs), .xrt(xrt), .y(y),
    .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src),
    .reg_wrt(reg_wrt), .branch_zero(branch_zero), .branch_neg(branch_neg), .jump(jump),
    .jump_mem(jump_mem), .wb_ctrl(wb_ctrl), .alu_result(alu_result), .z(z), .n(n),
    .read_data(read_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm);
    opcode = op; xrs = a; xrt = b; y = imm;
    #1;
  endtask

  initial begin
    // {alu_op, mr, mw, src, rw, bz, bn, j, jm, wb}
    exp_dec[0]  = 13'b000_0000_0000_00;
    exp_dec[1]  = 13'b000_0000_0000_00;
    exp_dec[2]  = 13'b000_0000_0000_00;
    exp_dec[3]  = 13'b000_0100_0000_00;
    exp_dec[4]  = 13'b001_0001_0000_10;
    exp_dec[5]  = 13'b001_0011_0000_10;
    exp_dec[6]  = 13'b011_0001_0000_10;
    exp_dec[7]  = 13'b010_0001_0000_10;
    exp_dec[8]  = 13'b000_0000_0010_00;
    exp_dec[9]  = 13'b000_0000_1000_00;
    exp_dec[10] = 13'b000_1000_0011_00;
    exp_dec[11] = 13'b000_0000_0100_00;
    exp_dec[12] = 13'b000_0000_0000_00;
    exp_dec[13] = 13'b000_0000_0000_00;
    exp_dec[14] = 13'b000_1001_0000_01;
    exp_dec[15] = 13'b000_0001_0000_00;

    drive(4'b1110, 32'h0, 32'h0, 32'h0);
    check("reset_mem0", read_data, 32'h0);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(4'(i), 32'h0, 32'h0, 32'h0);
      check($sformatf("decode_%0d", i),
            {19'd0, alu_op, mem_read, mem_write, alu_src, reg_wrt, branch_zero,
             branch_neg, jump, jump_mem, wb_ctrl}, {19'd0, exp_dec[i]});
    end

    drive(4'b0111, 32'd5, 32'd5, 32'h0);
    check("sub_eq_res", alu_result, 32'h0);
    check("sub_eq_zn", {30'd0, z, n}, 32'b10);
    drive(4'b0111, 32'd3, 32'd7, 32'h0);
    check("sub_neg_res", alu_result, 32'hFFFF_FFFC);
    check("sub_neg_zn", {30'd0, z, n}, 32'b01);
    drive(4'b0110, 32'd1, 32'h0, 32'h0);
    check("neg_one", alu_result, 32'hFFFF_FFFF);
    drive(4'b0100, 32'hFFFF_FFFF, 32'd1, 32'd100);
    check("add_wrap_res", alu_result, 32'h0);
    check("add_wrap_z", {31'd0, z}, 32'd1);
    drive(4'b0101, 32'd10, 32'd1, 32'hFFFF_FFFE);
    check("inc_imm", alu_result, 32'd8);
    drive(4'b1001, 32'h8000_0001, 32'd9, 32'd9);
    check("brz_pass", alu_result, 32'h8000_0001);
    check("brz_n", {31'd0, n}, 32'd1);

    @(negedge clock);
    drive(4'b0011, 32'h10, 32'hDEAD_BEEF, 32'h0);
    @(posedge clock); #1;
    drive(4'b1110, 32'h10, 32'h0, 32'h0);
    check("ld_after_st", read_data, 32'hDEAD_BEEF);
    drive(4'b0100, 32'h10, 32'h0, 32'h0);
    check("rd_gated", read_data, 32'h0);
    drive(4'b1010, 32'h10, 32'h0, 32'h0);
    check("jm_read", read_data, 32'hDEAD_BEEF);

    @(negedge clock);
    drive(4'b0011, 32'h110, 32'd7, 32'h0);
    @(posedge clock); #1;
    drive(4'b1110, 32'h10, 32'h0, 32'h0);
    check("addr_wrap", read_data, 32'd7);

    @(negedge clock);
    drive(4'b0011, 32'h3, 32'h55, 32'h0);
    @(posedge clock); #1;
    drive(4'b1110, 32'h3, 32'h0, 32'h0);
    check("st_55", read_data, 32'h55);
    #2 rst_n = 1'b0;
    #1 check("rst_clear", read_data, 32'h0);
    drive(4'b0011, 32'h3, 32'hAA, 32'h0);
    @(posedge clock); #1;
    drive(4'b1110, 32'h3, 32'h0, 32'h0);
    check("st_blocked", read_data, 32'h0);
    drive(4'b1110, 32'h10, 32'h0, 32'h0);
    check("rst_clear_10", read_data, 32'h0);
    @(negedge clock);
    rst_n = 1'b1;
    drive(4'b0011, 32'h3, 32'h1234, 32'h0);
    @(posedge clock); #1;
    drive(4'b1110, 32'h3, 32'h0, 32'h0);
    check("first_wr_after_rst", read_data, 32'h1234);

    @(negedge clock);
    drive(4'b0011, 32'h3, 32'h9, 32'h0);
    opcode = 4'b1111;
    #1 check("svpc_no_write", {31'd0, mem_write}, 32'd0);
    @(posedge clock); #1;
    drive(4'b1110, 32'h3, 32'h0, 32'h0);
    check("no_write_kept", read_data, 32'h1234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
